// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit (master) and imem (slave).
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM and IF/ID register.
// Optional stall counter output enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_write,
    input  logic                if_id_write,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic                if_id_valid,
    output logic [31:0]         if_id_pc,
    output logic [31:0]         if_id_instr
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] req_pc, req_pc_d;
    logic [31:0] buf_pc, buf_pc_d;
    logic [31:0] buf_instr, buf_instr_d;
    logic        id_valid_d;
    logic [31:0] id_pc_d, id_instr_d;
    logic        req_fire;

    assign imem.imem_req_valid = (state == ST_FETCH) && pc_write && !redirect_valid;
    assign imem.imem_req_addr  = pc;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        req_pc_d    = req_pc;
        buf_pc_d    = buf_pc;
        buf_instr_d = buf_instr;
        id_valid_d  = if_id_valid;
        id_pc_d     = if_id_pc;
        id_instr_d  = if_id_instr;

        if (redirect_valid) begin
            // Redirect wins regardless of stall inputs; an in-flight request must still drain.
            pc_d       = {redirect_pc[31:2], 2'b00};
            id_valid_d = 1'b0;
            if ((state == ST_WAIT && !imem.imem_resp_valid) || state == ST_DISCARD)
                state_d = ST_DISCARD;
            else
                state_d = ST_FETCH;
        end else begin
            if (if_id_write)
                id_valid_d = 1'b0;
            unique case (state)
                ST_FETCH: begin
                    if (req_fire) begin
                        req_pc_d = pc;
                        pc_d     = pc + 32'd4;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        if (if_id_write) begin
                            id_valid_d = 1'b1;
                            id_pc_d    = req_pc;
                            id_instr_d = imem.imem_resp_data;
                            state_d    = ST_FETCH;
                        end else begin
                            buf_pc_d    = req_pc;
                            buf_instr_d = imem.imem_resp_data;
                            state_d     = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (if_id_write) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = buf_pc;
                        id_instr_d = buf_instr;
                        state_d    = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (imem.imem_resp_valid)
                        state_d = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            req_pc      <= '0;
            buf_pc      <= '0;
            buf_instr   <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            req_pc      <= req_pc_d;
            buf_pc      <= buf_pc_d;
            buf_instr   <= buf_instr_d;
            if_id_valid <= id_valid_d;
            if_id_pc    <= id_pc_d;
            if_id_instr <= id_instr_d;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (!pc_write && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
